corner_coord_fifo: RTL and testbench

CORNER_COORD_FIFO -- requirements
Module: corner_coord_fifo

---
 rtl/corner_coord_fifo_if.sv | 27 ++
 rtl/corner_coord_fifo.sv | 82 ++++++++
 tb/tb_corner_coord_fifo.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/corner_coord_fifo_if.sv
// corner_coord_fifo_if: pixel-result input and coordinate-record output bundle for corner_coord_fifo
// Ports (signals): in_valid/in_sof/in_corner/in_score from the detector;
// out_valid/out_ready/out_data/out_eof record stream; drop_cnt status.
// master = producer/consumer side, slave = the FIFO.
interface corner_coord_fifo_if #(
  parameter int X_BITS  = 11,
  parameter int Y_BITS  = 10,
  parameter int SCORE_W = 8
);
  logic                              in_valid;
  logic                              in_sof;
  logic                              in_corner;
  logic [SCORE_W-1:0]                in_score;
  logic                              out_valid;
  logic                              out_ready;
  logic [Y_BITS+X_BITS+SCORE_W-1:0]  out_data;
  logic                              out_eof;
  logic [15:0]                       drop_cnt;
  modport master (
    output in_valid, in_sof, in_corner, in_score, out_ready,
    input  out_valid, out_data, out_eof, drop_cnt
  );
  modport slave (
    input  in_valid, in_sof, in_corner, in_score, out_ready,
    output out_valid, out_data, out_eof, drop_cnt
  );
endinterface

// File: rtl/corner_coord_fifo.sv
// corner_coord_fifo: tags detected corners with (x,y), queues {y,x,score} records plus an end-of-frame count record
// Ports: c clock; rst_n async active-low reset; bus (slave) carries the pixel-result
// inputs, the first-word-fall-through record output and the saturating drop counter.
module corner_coord_fifo #(
  parameter int IMG_W   = 1280,
  parameter int IMG_H   = 800,
  parameter int X_BITS  = 11,
  parameter int Y_BITS  = 10,
  parameter int SCORE_W = 8,
  parameter int DEPTH   = 16
) (
  input logic                c,
  input logic                rst_n,
  corner_coord_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = Y_BITS + X_BITS + SCORE_W;
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(IMG_W - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(IMG_H - 1);
  localparam logic [AW:0]       FULL   = (AW+1)'(DEPTH);
  logic [X_BITS-1:0] r_x, w_px, w_nx;
  logic [Y_BITS-1:0] r_y, w_py, w_ny;
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_cnt;
  logic [DW:0]       r_mem [DEPTH];
  logic [DW:0]       w_wdata, w_head;
  logic [15:0]       r_frame, r_drop, w_fc_base, w_fc_next;
  logic              r_eof_pend;
  logic              w_xw, w_last, w_full, w_eof_wr, w_cor_wr, w_push, w_pop, w_nz, w_drop;
  always_comb begin
    // an SOF pixel is (0,0) whatever the counters say
    w_px      = bus.in_sof ? '0 : r_x;
    w_py      = bus.in_sof ? '0 : r_y;
    w_xw      = w_px == X_LAST;
    w_last    = bus.in_valid && w_xw && w_py == Y_LAST;
    w_nx      = w_xw ? '0 : w_px + 1'b1;
    w_ny      = w_xw ? (w_py == Y_LAST ? '0 : w_py + 1'b1) : w_py;
    // full is judged on the registered occupancy, so a same-cycle pop never frees a slot
    w_full    = r_cnt == FULL;
    w_nz      = r_cnt != '0;
    w_eof_wr  = r_eof_pend && !w_full;
    w_cor_wr  = bus.in_valid && bus.in_corner && !w_full && !r_eof_pend;
    w_push    = w_eof_wr || w_cor_wr;
    w_pop     = w_nz && bus.out_ready;
    w_drop    = bus.in_valid && bus.in_corner && !w_cor_wr;
    w_wdata   = w_eof_wr ? {1'b1, DW'(r_frame)} : {1'b0, w_py, w_px, bus.in_score};
    w_fc_base = (w_eof_wr || (bus.in_valid && bus.in_sof && !r_eof_pend)) ? '0 : r_frame;
    w_fc_next = (w_cor_wr && w_fc_base != 16'hFFFF) ? w_fc_base + 1'b1 : w_fc_base;
    w_head    = r_mem[r_rp];
  end
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_eof_pend <= 1'b0;
      r_frame    <= '0;
      r_drop     <= '0;
    end else begin
      if (bus.in_valid) begin
        r_x <= w_nx;
        r_y <= w_ny;
      end
      // a new frame's last pixel re-arms the marker even as the previous one is written
      r_eof_pend <= w_last || (r_eof_pend && !w_eof_wr);
      r_frame    <= w_fc_next;
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge c) begin
    if (w_push) r_mem[r_wp] <= w_wdata;
  end
  assign bus.out_valid = w_nz;
  assign bus.out_eof   = w_nz && w_head[DW];
  assign bus.out_data  = w_nz ? w_head[DW-1:0] : '0;
  assign bus.drop_cnt  = r_drop;
endmodule

// File: tb/tb_corner_coord_fifo.sv
// tb_corner_coord_fifo: directed and random stimulus against a queue-based frame model
module tb_corner_coord_fifo;
  localparam int W = 4, H = 2, D = 4;
  logic c = 1'b0;
  logic rst_n;
  int checks = 0, errors = 0;
  corner_coord_fifo_if #(.X_BITS(11), .Y_BITS(10), .SCORE_W(8)) bus ();
  corner_coord_fifo #(.IMG_W(W), .IMG_H(H), .X_BITS(11), .Y_BITS(10), .SCORE_W(8), .DEPTH(D))
    dut (.c(c), .rst_n(rst_n), .bus(bus));
  always #5 c = ~c;
  logic [29:0] mq[$];
  logic [29:0] got[$];
  int mp, mfc, mdrop;
  bit mep;
  function automatic void chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, a, e);
    end
  endfunction
  // frame model: pixel index within the frame, record queue, counts
  always @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); mp = 0; mfc = 0; mdrop = 0; mep = 0;
    end else begin : stepm
      bit full, ewr, cwr, v;
      int p;
      v    = bus.in_valid;
      full = mq.size() == D;
      p    = bus.in_sof ? 0 : mp;
      ewr  = mep && !full;
      cwr  = v && bus.in_corner && !full && !mep;
      if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
      if (ewr) begin
        mq.push_back({1'b1, 29'(mfc)});
        mfc = 0;
      end else if (v && bus.in_sof && !mep) mfc = 0;
      if (cwr) begin
        mq.push_back({1'b0, 29'(((p / W) << 19) | ((p % W) << 8) | int'(bus.in_score))});
        if (mfc < 65535) mfc++;
      end
      if (v && bus.in_corner && !cwr && mdrop < 65535) mdrop++;
      mep = (mep && !ewr) || (v && p == W * H - 1);
      if (v) mp = (p + 1) % (W * H);
    end
  end
  always @(negedge c) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_data", 32'(bus.out_data), 0);
      chk("rst_eof", 32'(bus.out_eof), 0);
      chk("rst_drop", 32'(bus.drop_cnt), 0);
    end else begin
      chk("valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("data", 32'(bus.out_data), 32'(mq[0][28:0]));
        chk("eof", 32'(bus.out_eof), 32'(mq[0][29]));
      end
      chk("drop", 32'(bus.drop_cnt), 32'(mdrop));
      if (bus.out_valid && bus.out_ready) got.push_back({bus.out_eof, bus.out_data});
    end
  end
  task automatic step(input bit v, input bit s, input bit cr, input int sc, input bit r);
    bus.in_valid  = v;
    bus.in_sof    = s;
    bus.in_corner = cr;
    bus.in_score  = sc[7:0];
    bus.out_ready = r;
    @(posedge c);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_sof = 0; bus.in_corner = 0; bus.in_score = 0; bus.out_ready = 0;
    @(posedge c);
    #1;
    do_reset();
    got.delete();
    for (int i = 0; i < 8; i++) step(1, i == 0, i == 1 || i == 6, i == 1 ? 5 : (i == 6 ? 9 : 0), 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    chk("s1_count", 32'(got.size()), 3);
    chk("s1_rec0", 32'(got[0]), 32'h105);
    chk("s1_rec1", 32'(got[1]), 32'h80209);
    chk("s1_eof", 32'(got[2]), 32'h20000002);
    chk("s1_empty", 32'(bus.out_valid), 0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1, i == 0, i < 5, i + 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    chk("s2_drop", 32'(bus.drop_cnt), 1);
    chk("s2_occ", 32'(mq.size()), 4);
    chk("s2_pend", 32'(mep), 1);
    step(0, 0, 0, 0, 1);
    chk("s2_pop_occ", 32'(mq.size()), 3);
    chk("s2_still_pend", 32'(mep), 1);
    step(0, 0, 0, 0, 0);
    chk("s2_eof_occ", 32'(mq.size()), 4);
    chk("s2_eof_done", 32'(mep), 0);
    chk("s2_head", 32'(bus.out_data), 32'h102);
    step(1, 0, 1, 7, 1);
    chk("s3_occ", 32'(mq.size()), 3);
    chk("s3_drop", 32'(bus.drop_cnt), 2);
    bus.out_ready = 0;
    bus.in_valid = 0;
    bus.in_corner = 0;
    @(posedge c);
    #3 rst_n = 1'b0;
    #1;
    chk("s4_async_valid", 32'(bus.out_valid), 0);
    chk("s4_async_drop", 32'(bus.drop_cnt), 0);
    @(posedge c);
    #1 rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("s4_rel_drop", 32'(bus.drop_cnt), 0);
    chk("s4_rel_valid", 32'(bus.out_valid), 0);
    got.delete();
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);
    step(1, 1, 1, 3, 1);
    step(1, 0, 1, 4, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    chk("s5_count", 32'(got.size()), 2);
    chk("s5_sof_rec", 32'(got[0]), 32'h3);
    chk("s5_next_rec", 32'(got[1]), 32'h104);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
    end
    do_reset();
    for (int i = 0; i < 70004; i++) step(1, 0, 1, 1, 0);
    chk("s6_sat", 32'(bus.drop_cnt), 32'hFFFF);
    chk("s6_model_sat", 32'(mdrop), 65535);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
